res_station: RTL and testbench

RES_STATION -- requirements
Module: res_station

---
 rtl/qu_common.sv | 25 ++
 rtl/res_st_prio_enc.sv | 26 ++
 rtl/res_station.sv | 185 ++++++++++++++++++
 tb/tb_res_station.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// Shared queue/reservation-station types and default sizing.
// Imported by the reservation station and its priority encoder.
package qu_common;

  localparam int RS_DEPTH      = 8;
  localparam int RS_N_CDB      = 2;
  localparam int RS_TAG_WIDTH  = 5;
  localparam int RS_DATA_WIDTH = 32;
  localparam int RS_OP_WIDTH   = 13;
  localparam int RS_A_WIDTH    = 12;

  typedef struct packed {
    logic                     busy;
    logic                     pj;
    logic                     pk;
    logic [RS_OP_WIDTH-1:0]   op;
    logic [RS_TAG_WIDTH-1:0]  qj;
    logic [RS_TAG_WIDTH-1:0]  qk;
    logic [RS_DATA_WIDTH-1:0] vj;
    logic [RS_DATA_WIDTH-1:0] vk;
    logic [RS_A_WIDTH-1:0]    a;
    logic [RS_TAG_WIDTH-1:0]  tag;
  } rs_entry_t;

endpackage

// File: rtl/res_st_prio_enc.sv
// Lowest-index-set priority encoder with found flag.
// Used for free-slot and issue selection in res_station.
module res_st_prio_enc
  import qu_common::*;
#(
  parameter int N = RS_DEPTH,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // scan downward so the lowest set bit wins
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/res_station.sv
// Reservation station: dispatch, CDB wakeup with bypass,
// lowest-index issue, flush and occupancy tracking.
module res_station
  import qu_common::*;
#(
  parameter int DEPTH      = RS_DEPTH,
  parameter int DATA_WIDTH = RS_DATA_WIDTH,
  parameter int TAG_WIDTH  = RS_TAG_WIDTH,
  parameter int OP_WIDTH   = RS_OP_WIDTH,
  parameter int A_WIDTH    = RS_A_WIDTH,
  parameter int N_CDB      = RS_N_CDB
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [OP_WIDTH-1:0]         disp_op,
  input  logic [A_WIDTH-1:0]          disp_a,
  input  logic [TAG_WIDTH-1:0]        disp_tag,
  input  logic [DATA_WIDTH-1:0]       disp_vj,
  input  logic [DATA_WIDTH-1:0]       disp_vk,
  input  logic [TAG_WIDTH-1:0]        disp_qj,
  input  logic [TAG_WIDTH-1:0]        disp_qk,
  input  logic                        disp_pj,
  input  logic                        disp_pk,
  input  logic [N_CDB-1:0]            cdb_valid,
  input  logic [N_CDB*TAG_WIDTH-1:0]  cdb_tag,
  input  logic [N_CDB*DATA_WIDTH-1:0] cdb_data,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [OP_WIDTH-1:0]         iss_op,
  output logic [A_WIDTH-1:0]          iss_a,
  output logic [TAG_WIDTH-1:0]        iss_tag,
  output logic [DATA_WIDTH-1:0]       iss_vj,
  output logic [DATA_WIDTH-1:0]       iss_vk,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;

  typedef struct packed {
    logic                  busy;
    logic                  pj;
    logic                  pk;
    logic [OP_WIDTH-1:0]   op;
    logic [TAG_WIDTH-1:0]  qj;
    logic [TAG_WIDTH-1:0]  qk;
    logic [DATA_WIDTH-1:0] vj;
    logic [DATA_WIDTH-1:0] vk;
    logic [A_WIDTH-1:0]    a;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  entry_t                ent [DEPTH];
  logic [DEPTH-1:0]      busy_vec;
  logic [DEPTH-1:0]      rdy_vec;
  logic [IW-1:0]         free_idx;
  logic                  free_found;
  logic [IW-1:0]         iss_idx;
  logic                  iss_found;
  logic                  disp_fire;
  logic                  iss_fire;
  logic [DATA_WIDTH:0]   byp_j;
  logic [DATA_WIDTH:0]   byp_k;
  logic [DATA_WIDTH:0]   wk_j [DEPTH];
  logic [DATA_WIDTH:0]   wk_k [DEPTH];

  // {hit, data} for a tag; lowest-index matching channel wins
  function automatic logic [DATA_WIDTH:0] cdb_lookup(
    input logic [TAG_WIDTH-1:0] t
  );
    logic [DATA_WIDTH:0] r;
    r = '0;
    for (int c = N_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] &&
          cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == t)
        r = {1'b1, cdb_data[c*DATA_WIDTH +: DATA_WIDTH]};
    end
    return r;
  endfunction

  // busy/ready vectors and CDB match results per operand
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i] = ent[i].busy;
      rdy_vec[i]  = ent[i].busy & ~ent[i].pj & ~ent[i].pk;
      wk_j[i]     = cdb_lookup(ent[i].qj);
      wk_k[i]     = cdb_lookup(ent[i].qk);
    end
    byp_j = cdb_lookup(disp_qj);
    byp_k = cdb_lookup(disp_qk);
  end

  res_st_prio_enc #(.N(DEPTH), .W(IW)) u_free_sel (
    .req   (~busy_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  res_st_prio_enc #(.N(DEPTH), .W(IW)) u_iss_sel (
    .req   (rdy_vec),
    .idx   (iss_idx),
    .found (iss_found)
  );

  assign disp_ready = (occupancy < OW'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready & free_found;
  assign iss_fire   = iss_valid & iss_ready;

  // issue port, zeroed when nothing is ready
  always_comb begin
    iss_valid = iss_found;
    iss_op    = '0;
    iss_a     = '0;
    iss_tag   = '0;
    iss_vj    = '0;
    iss_vk    = '0;
    if (iss_found) begin
      iss_op  = ent[iss_idx].op;
      iss_a   = ent[iss_idx].a;
      iss_tag = ent[iss_idx].tag;
      iss_vj  = ent[iss_idx].vj;
      iss_vk  = ent[iss_idx].vk;
    end
  end

  // entry state: wakeup, issue release, dispatch write, flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].busy <= 1'b0;
        ent[i].pj   <= 1'b0;
        ent[i].pk   <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].busy <= 1'b0;
        ent[i].pj   <= 1'b0;
        ent[i].pk   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].busy && ent[i].pj && wk_j[i][DATA_WIDTH]) begin
          ent[i].vj <= wk_j[i][DATA_WIDTH-1:0];
          ent[i].pj <= 1'b0;
        end
        if (ent[i].busy && ent[i].pk && wk_k[i][DATA_WIDTH]) begin
          ent[i].vk <= wk_k[i][DATA_WIDTH-1:0];
          ent[i].pk <= 1'b0;
        end
        if (iss_fire && iss_idx == IW'(i))
          ent[i].busy <= 1'b0;
      end
      if (disp_fire) begin
        ent[free_idx].busy <= 1'b1;
        ent[free_idx].op   <= disp_op;
        ent[free_idx].a    <= disp_a;
        ent[free_idx].tag  <= disp_tag;
        ent[free_idx].qj   <= disp_qj;
        ent[free_idx].qk   <= disp_qk;
        ent[free_idx].pj   <= disp_pj & ~byp_j[DATA_WIDTH];
        ent[free_idx].pk   <= disp_pk & ~byp_k[DATA_WIDTH];
        ent[free_idx].vj   <= (disp_pj && byp_j[DATA_WIDTH]) ?
                              byp_j[DATA_WIDTH-1:0] : disp_vj;
        ent[free_idx].vk   <= (disp_pk && byp_k[DATA_WIDTH]) ?
                              byp_k[DATA_WIDTH-1:0] : disp_vk;
      end
    end
  end

  // busy count: +1 dispatch, -1 issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      occupancy <= '0;
    else if (flush)
      occupancy <= '0;
    else if (disp_fire && !iss_fire)
      occupancy <= occupancy + OW'(1);
    else if (!disp_fire && iss_fire)
      occupancy <= occupancy - OW'(1);
  end

endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station with DEPTH=8, N_CDB=2.
// One task per scenario, inline checks, single summary line.
module tb_res_station;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [12:0] disp_op;
  logic [11:0] disp_a;
  logic [4:0]  disp_tag;
  logic [31:0] disp_vj, disp_vk;
  logic [4:0]  disp_qj, disp_qk;
  logic        disp_pj, disp_pk;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [12:0] iss_op;
  logic [11:0] iss_a;
  logic [4:0]  iss_tag;
  logic [31:0] iss_vj, iss_vk;
  logic [3:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  res_station dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_op    (disp_op),
    .disp_a     (disp_a),
    .disp_tag   (disp_tag),
    .disp_vj    (disp_vj),
    .disp_vk    (disp_vk),
    .disp_qj    (disp_qj),
    .disp_qk    (disp_qk),
    .disp_pj    (disp_pj),
    .disp_pk    (disp_pk),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_op     (iss_op),
    .iss_a      (iss_a),
    .iss_tag    (iss_tag),
    .iss_vj     (iss_vj),
    .iss_vk     (iss_vk),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    disp_valid = 1'b0;
    disp_op    = '0;
    disp_a     = '0;
    disp_tag   = '0;
    disp_vj    = '0;
    disp_vk    = '0;
    disp_qj    = '0;
    disp_qk    = '0;
    disp_pj    = 1'b0;
    disp_pk    = 1'b0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    cdb_data   = '0;
  endtask

  task automatic disp(input logic [31:0] vj, input logic [4:0] qj,
                      input logic pj, input logic [4:0] tag);
    disp_valid = 1'b1;
    disp_op    = 13'h1A5;
    disp_a     = 12'h3C;
    disp_tag   = tag;
    disp_vj    = vj;
    disp_vk    = 32'h7;
    disp_qj    = qj;
    disp_qk    = 5'd0;
    disp_pj    = pj;
    disp_pk    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iss_ready = 1'b0;
    idle_inputs();
    step();
    step();
    n_checks += 4;
    if (disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_disp_ready got %b exp 1", disp_ready);
    end
    if (iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_iss_valid got %b exp 0", iss_valid);
    end
    if (occupancy !== 4'd0) begin
      n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy);
    end
    if (iss_vj !== 32'h0) begin
      n_fail++; $display("FAIL reset_iss_vj got %h exp 0", iss_vj);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_simple_issue();
    iss_ready = 1'b1;
    disp(32'd5, 5'd0, 1'b0, 5'd9);
    step();
    idle_inputs();
    n_checks += 5;
    if (iss_valid !== 1'b1) begin
      n_fail++; $display("FAIL simple_valid got %b exp 1", iss_valid);
    end
    if (iss_vj !== 32'd5 || iss_vk !== 32'd7) begin
      n_fail++;
      $display("FAIL simple_ops got %0d/%0d exp 5/7", iss_vj, iss_vk);
    end
    if (iss_tag !== 5'd9) begin
      n_fail++; $display("FAIL simple_tag got %0d exp 9", iss_tag);
    end
    if (occupancy !== 4'd1) begin
      n_fail++; $display("FAIL simple_occ1 got %0d exp 1", occupancy);
    end
    step();
    if (occupancy !== 4'd0) begin
      n_fail++; $display("FAIL simple_occ0 got %0d exp 0", occupancy);
    end
  endtask

  task automatic test_cdb_wakeup();
    iss_ready = 1'b1;
    disp(32'h0, 5'd3, 1'b1, 5'd10);
    step();
    idle_inputs();
    n_checks += 4;
    if (iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL wake_pending got %b exp 0", iss_valid);
    end
    step();
    cdb_valid = 2'b01;
    cdb_tag   = {5'd0, 5'd3};
    cdb_data  = {32'h0, 32'hDEAD};
    #1;
    if (iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL wake_comb_path got %b exp 0", iss_valid);
    end
    step();
    idle_inputs();
    if (iss_valid !== 1'b1 || iss_vj !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL wake_issue got %b/%h exp 1/dead", iss_valid, iss_vj);
    end
    step();
    if (occupancy !== 4'd0) begin
      n_fail++; $display("FAIL wake_drain got %0d exp 0", occupancy);
    end
  endtask

  task automatic test_bypass();
    iss_ready = 1'b1;
    disp(32'h0, 5'd4, 1'b1, 5'd11);
    cdb_valid = 2'b10;
    cdb_tag   = {5'd4, 5'd7};
    cdb_data  = {32'h11, 32'h22};
    step();
    idle_inputs();
    n_checks += 2;
    if (iss_valid !== 1'b1 || iss_vj !== 32'h11) begin
      n_fail++;
      $display("FAIL bypass got %b/%h exp 1/11", iss_valid, iss_vj);
    end
    step();
    if (occupancy !== 4'd0) begin
      n_fail++; $display("FAIL bypass_drain got %0d exp 0", occupancy);
    end
  endtask

  task automatic test_dup_tag();
    iss_ready = 1'b0;
    disp(32'h0, 5'd2, 1'b1, 5'd12);
    step();
    idle_inputs();
    cdb_valid = 2'b11;
    cdb_tag   = {5'd2, 5'd2};
    cdb_data  = {32'hB, 32'hA};
    step();
    idle_inputs();
    n_checks += 1;
    if (iss_valid !== 1'b1 || iss_vj !== 32'hA) begin
      n_fail++;
      $display("FAIL dup_tag got %b/%h exp 1/a", iss_valid, iss_vj);
    end
    iss_ready = 1'b1;
    step();
  endtask

  task automatic test_nonpending();
    iss_ready = 1'b0;
    disp(32'h55, 5'd6, 1'b0, 5'd13);
    step();
    idle_inputs();
    cdb_valid = 2'b01;
    cdb_tag   = {5'd0, 5'd6};
    cdb_data  = {32'h0, 32'h99};
    step();
    idle_inputs();
    step();
    n_checks += 1;
    if (iss_valid !== 1'b1 || iss_vj !== 32'h55) begin
      n_fail++;
      $display("FAIL nonpending got %b/%h exp 1/55", iss_valid, iss_vj);
    end
    iss_ready = 1'b1;
    step();
  endtask

  task automatic test_full();
    iss_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp(32'(i), 5'd0, 1'b0, 5'(i));
      step();
    end
    idle_inputs();
    n_checks += 6;
    if (occupancy !== 4'd8 || disp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full got occ %0d rdy %b exp 8/0", occupancy, disp_ready);
    end
    if (iss_valid !== 1'b1 || iss_vj !== 32'd0) begin
      n_fail++;
      $display("FAIL full_head got %b/%0d exp 1/0", iss_valid, iss_vj);
    end
    iss_ready = 1'b1;
    disp(32'hEE, 5'd0, 1'b0, 5'd20);
    step();
    iss_ready = 1'b0;
    idle_inputs();
    if (occupancy !== 4'd7 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_free got occ %0d rdy %b exp 7/1",
               occupancy, disp_ready);
    end
    if (iss_vj !== 32'd1) begin
      n_fail++; $display("FAIL full_next got %0d exp 1", iss_vj);
    end
    disp(32'h100, 5'd0, 1'b0, 5'd21);
    step();
    idle_inputs();
    if (occupancy !== 4'd8) begin
      n_fail++; $display("FAIL refill_occ got %0d exp 8", occupancy);
    end
    if (iss_vj !== 32'h100) begin
      n_fail++; $display("FAIL refill_idx got %h exp 100", iss_vj);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_flush_reset();
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(32'(i + 40), 5'd0, 1'b0, 5'(i));
      step();
    end
    n_checks += 5;
    if (occupancy !== 4'd5) begin
      n_fail++; $display("FAIL flush_pre got %0d exp 5", occupancy);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_inputs();
    if (occupancy !== 4'd0 || iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush got occ %0d v %b exp 0/0", occupancy, iss_valid);
    end
    if (disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_rdy got %b exp 1", disp_ready);
    end
    for (int i = 0; i < 3; i++) begin
      disp(32'(i + 60), 5'd0, 1'b0, 5'(i));
      step();
    end
    #1;
    rst_n = 1'b0;
    #1;
    if (occupancy !== 4'd0 || iss_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got occ %0d v %b exp 0/0", occupancy, iss_valid);
    end
    if (iss_vj !== 32'h0 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_out got %h rdy %b exp 0/1", iss_vj, disp_ready);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_simple_issue();
    test_cdb_wakeup();
    test_bypass();
    test_dup_tag();
    test_nonpending();
    test_full();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
